// File: rtl/gp_regfile_pc.sv
// Architectural state: x0-hardwired register file with N read ports, post-reset clear sequencer, and PC sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module gp_regfile_pc #(
  parameter int unsigned            XLEN           = 32,
  parameter int unsigned            NUM_REGS       = 32,
  parameter int unsigned            NUM_READ_PORTS = 2,
  parameter logic [XLEN-1:0]        RESET_PC       = {XLEN{1'b0}},
  localparam int unsigned           AW             = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ_PORTS*AW-1:0]   rd_addr,
  output logic [NUM_READ_PORTS*XLEN-1:0] rd_data,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [XLEN-1:0]                wr_data,
  input  logic                           pc_stall,
  input  logic                           pc_load,
  input  logic [XLEN-1:0]                pc_target,
  output logic [XLEN-1:0]                pc,
  output logic                           pc_misaligned,
  output logic                           ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0]   ZERO_AW  = {AW{1'b0}};
  localparam logic [AW-1:0]   FIRST_IDX = AW'(1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clear_idx;
  logic [AW-1:0]   w_clear_idx_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_misaligned;
  logic            w_misaligned_nxt;
  logic [XLEN-1:0] r_regs [NUM_REGS];

  logic            w_wr_fire;
  logic            w_reg_we;
  logic [AW-1:0]   w_reg_waddr;
  logic [XLEN-1:0] w_reg_wdata;

  assign w_wr_fire = (r_state == RUN) && wr_en && (wr_addr != ZERO_AW);

  // Next-state: clear sequencing, architectural write selection, PC priority chain
  always_comb begin
    w_state_nxt      = r_state;
    w_clear_idx_nxt  = r_clear_idx;
    w_pc_nxt         = r_pc;
    w_misaligned_nxt = 1'b0;
    w_reg_we         = 1'b0;
    w_reg_waddr      = wr_addr;
    w_reg_wdata      = wr_data;
    case (r_state)
      CLEAR: begin
        w_reg_we        = 1'b1;
        w_reg_waddr     = r_clear_idx;
        w_reg_wdata     = ZERO_X;
        w_clear_idx_nxt = r_clear_idx + FIRST_IDX;
        if (r_clear_idx == LAST_IDX) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = CLEAR;
        end
      end
      RUN: begin
        w_reg_we = w_wr_fire;
        // A misaligned redirect is rejected outright and still wins over stall
        if (pc_load) begin
          if (pc_target[1:0] == 2'b00) begin
            w_pc_nxt = pc_target;
          end else begin
            w_pc_nxt         = r_pc;
            w_misaligned_nxt = 1'b1;
          end
        end else if (pc_stall) begin
          w_pc_nxt = r_pc;
        end else begin
          w_pc_nxt = r_pc + PC_STEP;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= CLEAR;
      r_clear_idx  <= FIRST_IDX;
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_idx  <= w_clear_idx_nxt;
      r_pc         <= w_pc_nxt;
      r_misaligned <= w_misaligned_nxt;
    end
  end

  // Register storage; contents only become defined through the clear sequence
  always_ff @(posedge clk) begin
    if (reset && w_reg_we) begin
      r_regs[w_reg_waddr] <= w_reg_wdata;
    end
  end

  // Combinational read ports; everything reads zero until clearing is done
  always_comb begin
    rd_data = {(NUM_READ_PORTS*XLEN){1'b0}};
    for (int i = 0; i < int'(NUM_READ_PORTS); i++) begin
      if ((r_state != RUN) || (rd_addr[i*AW +: AW] == ZERO_AW)) begin
        rd_data[i*XLEN +: XLEN] = ZERO_X;
`ifdef REGFILE_BYPASS_EN
      end else if (w_wr_fire && (rd_addr[i*AW +: AW] == wr_addr)) begin
        rd_data[i*XLEN +: XLEN] = wr_data;
`endif
      end else begin
        rd_data[i*XLEN +: XLEN] = r_regs[rd_addr[i*AW +: AW]];
      end
    end
  end

  assign pc            = r_pc;
  assign pc_misaligned = r_misaligned;
  assign ready         = (r_state == RUN);

endmodule

// File: tb/tb_gp_regfile_pc.sv
// Scoreboard bench for gp_regfile_pc: expectations are queued with stimulus and drained after outputs settle.
module tb_gp_regfile_pc;

  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          pc_stall;
  logic          pc_load;
  logic [31:0]   pc_target;
  logic [31:0]   pc;
  logic          pc_misaligned;
  logic          ready;

  gp_regfile_pc dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pc_stall      (pc_stall),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .pc            (pc),
    .pc_misaligned (pc_misaligned),
    .ready         (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int SEL_RD0 = 0;
  localparam int SEL_RD1 = 1;
  localparam int SEL_PC  = 2;
  localparam int SEL_MIS = 3;
  localparam int SEL_RDY = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hCAFE_F00D;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD0: return rd_data[31:0];
      SEL_RD1: return rd_data[63:32];
      SEL_PC:  return pc;
      SEL_MIS: return {31'd0, pc_misaligned};
      SEL_RDY: return {31'd0, ready};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_value(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic run_clear(input string tag);
    for (int i = 1; i <= 31; i++) begin
      expect_val({tag, "_ready"}, SEL_RDY, (i == 31) ? 32'd1 : 32'd0);
      expect_val({tag, "_pc"}, SEL_PC, 32'h0000_0000);
      expect_val({tag, "_rd"}, SEL_RD0, 32'h0000_0000);
      tick();
    end
  endtask

  initial begin
    reset     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    pc_stall  = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;

    repeat (2) @(posedge clk);
    expect_val("rst_ready", SEL_RDY, 32'd0);
    expect_val("rst_pc", SEL_PC, 32'h0000_0000);
    expect_val("rst_mis", SEL_MIS, 32'd0);
    tick();

    // Release reset with a write to x5 pending throughout clearing
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hAAAA_AAAA;
    rd_addr = {5'd0, 5'd5};
    run_clear("clear");
    wr_en = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'd0, 5'(a)};
      expect_val("clear_all", SEL_RD0, 32'h0000_0000);
      settle();
    end

    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_addr = 5'd0;
    wr_data = 32'h0000_1234;
    tick();
    wr_en   = 1'b0;
    rd_addr = {5'd0, 5'd7};
    expect_val("rd_x7", SEL_RD0, 32'hDEAD_BEEF);
    expect_val("rd_x0", SEL_RD1, 32'h0000_0000);
    settle();
    rd_addr = {5'd7, 5'd7};
    expect_val("dual_p0", SEL_RD0, 32'hDEAD_BEEF);
    expect_val("dual_p1", SEL_RD1, 32'hDEAD_BEEF);
    settle();

    rd_addr = {5'd0, 5'd3};
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hCAFE_F00D;
    expect_val("bypass", SEL_RD0, BYP_EXP);
    settle();
    tick();
    wr_en = 1'b0;
    expect_val("after_wr_x3", SEL_RD0, 32'hCAFE_F00D);
    settle();

    pc_load   = 1'b1;
    pc_target = 32'h0000_0100;
    expect_val("pc_load100", SEL_PC, 32'h0000_0100);
    tick();
    pc_load = 1'b0;
    expect_val("pc_seq0", SEL_PC, 32'h0000_0104);
    tick();
    expect_val("pc_seq1", SEL_PC, 32'h0000_0108);
    tick();
    pc_stall = 1'b1;
    expect_val("pc_seq2", SEL_PC, 32'h0000_0108);
    tick();
    expect_val("pc_seq3", SEL_PC, 32'h0000_0108);
    tick();
    pc_stall = 1'b0;
    expect_val("pc_seq4", SEL_PC, 32'h0000_010C);
    tick();
    pc_stall  = 1'b1;
    pc_load   = 1'b1;
    pc_target = 32'h0000_2000;
    expect_val("load_over_stall", SEL_PC, 32'h0000_2000);
    tick();

    pc_stall  = 1'b0;
    pc_target = 32'h0000_2002;
    expect_val("mis_pc", SEL_PC, 32'h0000_2000);
    expect_val("mis_pulse", SEL_MIS, 32'd1);
    tick();
    expect_val("mis_b2b_pc", SEL_PC, 32'h0000_2000);
    expect_val("mis_b2b", SEL_MIS, 32'd1);
    tick();
    pc_load  = 1'b0;
    pc_stall = 1'b1;
    expect_val("mis_drop", SEL_MIS, 32'd0);
    expect_val("mis_hold_pc", SEL_PC, 32'h0000_2000);
    tick();

    pc_stall  = 1'b0;
    pc_load   = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    expect_val("wrap_load", SEL_PC, 32'hFFFF_FFFC);
    expect_val("wrap_mis", SEL_MIS, 32'd0);
    tick();
    pc_load = 1'b0;
    expect_val("wrap_zero", SEL_PC, 32'h0000_0000);
    tick();

    pc_load   = 1'b1;
    pc_target = 32'h0000_0040;
    wr_en     = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 32'h0000_0055;
    expect_val("mid_pc40", SEL_PC, 32'h0000_0040);
    tick();
    wr_en    = 1'b0;
    pc_load  = 1'b0;
    pc_stall = 1'b1;
    rd_addr  = {5'd0, 5'd9};
    expect_val("mid_x9", SEL_RD0, 32'h0000_0055);
    settle();
    reset = 1'b0;
    expect_val("mid_rst_pc", SEL_PC, 32'h0000_0000);
    expect_val("mid_rst_ready", SEL_RDY, 32'd0);
    tick();
    reset = 1'b1;
    run_clear("reclear");
    expect_val("x9_cleared", SEL_RD0, 32'h0000_0000);
    settle();
    pc_stall = 1'b0;
    expect_val("pc_after_reclear", SEL_PC, 32'h0000_0004);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gp_regfile_pc.md
Name: gp_regfile_pc

Overview:
- Parametrised architectural state block for the RISC-V core: general-purpose register file with x0 hardwired to zero, N read ports, one write port, and the program counter.
- Successor to the fixed 32x32 register bundle.
- Adds a post-reset clearing sequencer, write-to-read bypass, and PC sequencing: stall, redirect, increment, misalignment detect.
- Sits between decode (read ports), writeback (write port) and fetch (PC).

Parameters:
- XLEN, 32, register and PC width in bits.
- NUM_REGS, 32, architectural register count including x0; power of two, 2..64; AW = $clog2(NUM_REGS).
- NUM_READ_PORTS, 2, independent read ports, 1..4.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- rd_addr  input  NUM_READ_PORTS*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  output  NUM_READ_PORTS*XLEN  packed read data; port i at [i*XLEN +: XLEN].
- wr_en  input  1  write strobe from writeback.
- wr_addr  input  AW  write register index.
- wr_data  input  XLEN  write data.
- pc_stall  input  1  hold PC.
- pc_load  input  1  redirect PC (branch/jump).
- pc_target  input  XLEN  redirect target.
- pc  output  XLEN  current PC.
- pc_misaligned  output  1  one-cycle pulse: rejected misaligned redirect.
- ready  output  1  high once clearing is complete.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset; sampled only at the clk rising edge.
- Reset values while reset=0:
  - state=CLEAR, clear_idx=1, pc=RESET_PC.
  - pc_misaligned=0, ready=0.
  - Register contents are not reset directly; the clear sequence zeroes them.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to reg[clear_idx] and increments clear_idx.
  - When clear_idx == NUM_REGS-1 is written, go to RUN next cycle. CLEAR lasts NUM_REGS-1 cycles after reset release.
  - In CLEAR: wr_en is ignored (dropped, not queued), PC holds RESET_PC, pc_load/pc_stall are ignored, rd_data reads 0.
  - RUN: ready=1 and stays in RUN until reset.
  - Reset asserted mid-CLEAR or in RUN returns to CLEAR with clear_idx=1; the sequence restarts fully.
- Register reads:
  - Combinational; zero-cycle latency from rd_addr to rd_data.
  - rd_addr==0 always returns 0.
  - Out-of-range addresses cannot occur: NUM_REGS is a power of two.
- Register writes:
  - In RUN, when wr_en=1 and wr_addr!=0, reg[wr_addr] takes wr_data at the clock edge.
  - Writes to x0 are discarded.
  - Multiple read ports may read the same register in the same cycle.
- PC update in RUN, evaluated in this priority order:
  1. If pc_load=1 and pc_target[1:0]==0: pc <= pc_target.
  2. If pc_load=1 and pc_target[1:0]!=0: pc holds; pc_misaligned=1 next cycle for one cycle. pc_load takes priority over pc_stall.
  3. Else if pc_stall=1: pc holds.
  4. Else: pc <= pc + 4, modulo 2^XLEN; all-ones-minus-3 wraps to 0.
- pc_misaligned is registered and deasserts the following cycle unless another misaligned redirect occurs. Back-to-back misaligned redirects hold it high.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose rd_addr equals wr_addr, while wr_en=1, wr_addr!=0 and state=RUN, returns wr_data combinationally in the same cycle. This gives write-through; no extra latency.
- Not defined: a read in the same cycle returns the old contents; new data is visible from the next cycle.
- x0 reads return 0 in both builds.

Test Plan:
- Reset/clear: hold reset=0 for 3 cycles, release.
  - ready=0 for exactly 31 cycles, then 1.
  - pc=0x0 throughout CLEAR.
  - All registers read 0.
  - wr_en=1 to x5=0xAAAA_AAAA during CLEAR is dropped; x5 reads 0 after ready.
- Write/read:
  - In RUN, write x7=0xDEAD_BEEF and x0=0x1234.
  - Next cycle, port0 addr 7 -> 0xDEAD_BEEF; port1 addr 0 -> 0.
  - Both ports addr 7 -> both 0xDEAD_BEEF.
- Bypass: same cycle write x3=0xCAFE_F00D and read addr 3.
  - With REGFILE_BYPASS_EN: 0xCAFE_F00D.
  - Without: previous value 0.
- PC sequencing: from pc=0x100, apply free-run 2 cycles, then stall 2 cycles, then free-run 1 cycle.
  - Expected pc sequence: 0x104, 0x108, 0x108, 0x108, 0x10C.
  - pc_load=1, target=0x2000 with pc_stall=1 -> pc=0x2000.
- Misaligned/wrap:
  - pc_load target 0x2002 -> pc holds; pc_misaligned high exactly 1 cycle.
  - Redirect to 0xFFFF_FFFC then free-run -> pc=0x0000_0000.
- Reset mid-operation: assert reset=0 for 1 cycle at pc=0x40 with x9=0x55.
  - pc=RESET_PC, ready=0, 31-cycle clear repeats.
  - x9 reads 0 afterwards.
